mio_bus_arbiter: RTL and testbench
==================================

# mio_bus_arbiter

Two-master arbiter and transaction sequencer for the single shared memory/IO port. It sits between the multi-cycle CPU's memory interface (address, write data, write strobe, MIO_ready handshake) and a second bus master (DMA/peripheral engine). It grants the port to one master at a time, issues a single memory transaction, waits for the slave's acknowledge with a timeout, and returns read data plus a one-cycle ready pulse to the granted master.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 16, max cycles in WAIT before forced error completion (≥2)

- clk  in  1  single system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- cpu_req  in  1  CPU transaction request, level, held until cpu_ready
- cpu_we  in  1  CPU write (1) / read (0)
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  read data to CPU, valid with cpu_ready
- cpu_ready  out  1  one-cycle completion pulse to CPU (drives MIO_ready)
- dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_ready: same as cpu_* for second master
- err  out  1  completion was a timeout; valid with the ready pulse
- grant  out  1  owner of current transaction: 0 CPU, 1 DMA
- mem_en  out  1  memory strobe, exactly one cycle per transaction
- mem_we  out  1  latched write flag
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched write data
- mem_rdata  in  DATA_W  slave read data, valid with mem_ack
- mem_ack  in  1  slave completion

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req, choose winner; latch we/addr/wdata of winner into mem_* regs, set grant → ISSUE. No req: stay.
- Arbitration: single req wins; both req → the master not granted last (round-robin via last_grant bit). After reset last_grant=DMA, so CPU wins first tie.
- ISSUE: mem_en=1 for this cycle only. mem_ack sampled high → capture rdata, err=0 → RESP; else → WAIT, timer cleared.
- WAIT: mem_en=0, mem_* held stable. mem_ack → capture, → RESP. Timer reaches TIMEOUT-1 without ack → rdata=0, err=1 → RESP. Late ack after timeout ignored.
- RESP: ready pulse to granted master only; rdata output registered; last_grant←grant; → IDLE. Requests not sampled in RESP.
- Writes: mem_rdata ignored, rdata output 0.
- Requester rule: req, we, addr, wdata stable from assertion until ready; req dropped (or new request presented) after ready. Req changes before ready are undefined.

## Timing
- Reset (rst low, async): state IDLE, all outputs 0 (cpu_ready, dma_ready, err, grant, mem_en, mem_we, mem_addr, mem_wdata, rdata), timer 0, last_grant=1. Reset mid-transaction aborts it silently; no ready pulse.
- Minimum latency: req sampled at edge k → ISSUE cycle k; ack in same cycle → ready high during cycle k+1 (2 cycles req→ready).
- Ack after n WAIT cycles → ready n cycles later than minimum.
- Timeout: ready+err high exactly TIMEOUT cycles after the ISSUE cycle ends.
- Back-to-back: next grant no earlier than the edge ending the IDLE cycle following RESP; throughput max one transaction per 3 cycles.
- Timer width: clog2(TIMEOUT); never wraps (WAIT exits at TIMEOUT-1).

## Structure
- Shared package: FSM state encoding (2-bit IDLE=0, ISSUE=1, WAIT=2, RESP=3), master IDs (MST_CPU=0, MST_DMA=1).
- One natural sub-module: rr_arb2 (2-input round-robin picker, combinational, inputs req pair + last_grant, output winner + valid).
- Everything else single module; all outputs registered.

## Test plan
- CPU read, ack in ISSUE: cpu_addr=0x100, mem_rdata=0xDEADBEEF → mem_en one cycle with mem_addr=0x100, cpu_ready one cycle later, cpu_rdata=0xDEADBEEF, err=0, dma_ready=0.
- Simultaneous req out of reset, both held: CPU granted first, then DMA, then CPU; grant alternates 0,1,0.
- DMA write, ack after 3 WAIT cycles: dma_wdata=0x12345678 → mem_we=1, mem_wdata stable through WAIT, dma_ready 1 cycle after ack, dma_rdata=0.
- No ack, TIMEOUT=16: ready+err asserted 16 cycles after ISSUE, rdata=0; ack injected afterwards has no effect, FSM in IDLE.
- rst pulled low during WAIT: all outputs 0 immediately (async); after release, pending CPU req restarts from IDLE with fresh ISSUE.
- Only DMA requesting continuously, CPU idle: DMA served every 3 cycles with no CPU grant; CPU req raised mid-stream wins the next arbitration.

Source files
------------

// File: rtl/mio_bus_arbiter_pkg.sv
// Shared types and constants for the two-master memory/IO port arbiter.
package mio_bus_arbiter_pkg;

    // Transaction sequencer states; the encoding is fixed so debug tools can decode it.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    // Master identifiers as carried on the grant output and the last-grant bit.
    localparam logic MST_CPU = 1'b0;
    localparam logic MST_DMA = 1'b1;

    // On contention the master that was not served last takes the port.
    function automatic logic rr_tie_winner(input logic last_grant);
        return ~last_grant;
    endfunction

endpackage

// File: rtl/mio_bus_arbiter_rr_arb2.sv
// Two-input round-robin picker: a lone requester always wins, ties go to the
// master that was not granted last.
module mio_bus_arbiter_rr_arb2
    import mio_bus_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       winner_o,
    output logic       valid_o
);

    // Pick the winner from the request pair and the previous owner.
    always_comb begin
        winner_o = MST_CPU;
        valid_o  = 1'b0;
        case (req_i)
            2'b01: begin
                winner_o = MST_CPU;
                valid_o  = 1'b1;
            end
            2'b10: begin
                winner_o = MST_DMA;
                valid_o  = 1'b1;
            end
            2'b11: begin
                winner_o = rr_tie_winner(last_grant_i);
                valid_o  = 1'b1;
            end
            default: begin
                winner_o = MST_CPU;
                valid_o  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mio_bus_arbiter.sv
// Two-master arbiter and single-transaction sequencer for the shared memory/IO
// port. One transaction at a time: grant, one-cycle strobe, wait for ack with a
// timeout, then a one-cycle ready pulse with registered read data to the owner.
module mio_bus_arbiter
    import mio_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ready,
    output logic              err,
    output logic              grant,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    // The timer counts WAIT cycles and stops at TIMEOUT-1, so it never wraps.
    localparam int               TMR_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    arb_state_e        state_q;
    logic [TMR_W-1:0]  timer_q;
    logic              last_grant_q;
    logic              grant_q;
    logic              err_q;
    logic              cpu_ready_q;
    logic              dma_ready_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dma_rdata_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic              arb_winner_s;
    logic              arb_valid_s;
    logic              win_we_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic [DATA_W-1:0] win_wdata_s;
    logic              done_s;
    logic              timeout_s;
    logic [DATA_W-1:0] rsp_data_s;

    mio_bus_arbiter_rr_arb2 u_rr_arb2 (
        .req_i        ({dma_req, cpu_req}),
        .last_grant_i (last_grant_q),
        .winner_o     (arb_winner_s),
        .valid_o      (arb_valid_s)
    );

    // Route the winning master's transaction fields toward the latch registers.
    always_comb begin
        win_we_s    = cpu_we;
        win_addr_s  = cpu_addr;
        win_wdata_s = cpu_wdata;
        if (arb_winner_s == MST_DMA) begin
            win_we_s    = dma_we;
            win_addr_s  = dma_addr;
            win_wdata_s = dma_wdata;
        end else begin
            win_we_s    = cpu_we;
            win_addr_s  = cpu_addr;
            win_wdata_s = cpu_wdata;
        end
    end

    // Decide whether the outstanding transaction completes this cycle and how.
    always_comb begin
        done_s    = 1'b0;
        timeout_s = 1'b0;
        case (state_q)
            ST_ISSUE: begin
                done_s = mem_ack;
            end
            ST_WAIT: begin
                if (mem_ack) begin
                    done_s = 1'b1;
                end else if (timer_q == TMR_LAST) begin
                    done_s    = 1'b1;
                    timeout_s = 1'b1;
                end else begin
                    done_s = 1'b0;
                end
            end
            default: begin
                done_s    = 1'b0;
                timeout_s = 1'b0;
            end
        endcase
    end

    // Read data returned to the master: zero for writes and for timeouts.
    always_comb begin
        if (timeout_s || mem_we_q) begin
            rsp_data_s = {DATA_W{1'b0}};
        end else begin
            rsp_data_s = mem_rdata;
        end
    end

    // Sequencer FSM with all port-facing outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            timer_q      <= {TMR_W{1'b0}};
            last_grant_q <= MST_DMA;
            grant_q      <= MST_CPU;
            err_q        <= 1'b0;
            cpu_ready_q  <= 1'b0;
            dma_ready_q  <= 1'b0;
            cpu_rdata_q  <= {DATA_W{1'b0}};
            dma_rdata_q  <= {DATA_W{1'b0}};
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= {ADDR_W{1'b0}};
            mem_wdata_q  <= {DATA_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arb_valid_s) begin
                        grant_q     <= arb_winner_s;
                        mem_we_q    <= win_we_s;
                        mem_addr_q  <= win_addr_s;
                        mem_wdata_q <= win_wdata_s;
                        mem_en_q    <= 1'b1;
                        state_q     <= ST_ISSUE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ISSUE, ST_WAIT: begin
                    mem_en_q <= 1'b0;
                    if (done_s) begin
                        state_q <= ST_RESP;
                        err_q   <= timeout_s;
                        if (grant_q == MST_DMA) begin
                            dma_ready_q <= 1'b1;
                            dma_rdata_q <= rsp_data_s;
                        end else begin
                            cpu_ready_q <= 1'b1;
                            cpu_rdata_q <= rsp_data_s;
                        end
                    end else begin
                        state_q <= ST_WAIT;
                        if (state_q == ST_ISSUE) begin
                            timer_q <= {TMR_W{1'b0}};
                        end else begin
                            timer_q <= timer_q + TMR_W'(1);
                        end
                    end
                end
                ST_RESP: begin
                    cpu_ready_q  <= 1'b0;
                    dma_ready_q  <= 1'b0;
                    err_q        <= 1'b0;
                    last_grant_q <= grant_q;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ready = cpu_ready_q;
    assign dma_rdata = dma_rdata_q;
    assign dma_ready = dma_ready_q;
    assign err       = err_q;
    assign grant     = grant_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Self-checking bench for mio_bus_arbiter: directed scenarios plus a randomized
// stream, all checked against a transaction-level model of arbitration and timing.
module tb_mio_bus_arbiter;

    localparam int TIMEOUT = 16;

    logic        clk;
    logic        rst;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic [31:0] cpu_rdata, dma_rdata;
    logic        cpu_ready, dma_ready, err, grant;
    logic        mem_en, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int   checks   = 0;
    int   failures = 0;
    logic mdl_last = 1'b1;

    mio_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ready(dma_ready),
        .err(err), .grant(grant),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    // Reference arbitration rule: lone requester wins, a tie goes to the master not served last.
    function automatic logic exp_winner(input logic c, input logic d, input logic last);
        if (c && d) return ~last;
        if (d) return 1'b1;
        return 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Slave model: waits (bounded) for the strobe, acks on cycle ack_at after it
    // (0 = during the strobe cycle, -1 = never), and reports what it observed.
    task automatic serve(input int ack_at, input logic [31:0] rd, input int drop_m,
                         output int wn, output logic g, output logic we, output logic [31:0] a,
                         output logic [31:0] wd, output int lat, output logic cr, output logic dr,
                         output logic [31:0] crd, output logic [31:0] drd, output logic e,
                         output bit un, output bit pl);
        wn = 0; lat = -1; un = 1'b0; pl = 1'b0;
        cr = 1'b0; dr = 1'b0; crd = 32'h0; drd = 32'h0; e = 1'b0;
        do begin
            tick();
            wn++;
        end while (mem_en !== 1'b1 && wn < 20);
        g = grant; we = mem_we; a = mem_addr; wd = mem_wdata;
        if (mem_en !== 1'b1) return;
        for (int i = 0; i < 40; i++) begin
            mem_ack   = (i == ack_at);
            mem_rdata = (i == ack_at) ? rd : $urandom;
            tick();
            if (mem_en !== 1'b0 || grant !== g || mem_we !== we || mem_addr !== a || mem_wdata !== wd) un = 1'b1;
            if (cpu_ready === 1'b1 || dma_ready === 1'b1) begin
                lat = i + 1;
                break;
            end
        end
        mem_ack = 1'b0;
        cr = cpu_ready; dr = dma_ready; crd = cpu_rdata; drd = dma_rdata; e = err;
        if (drop_m == 0) cpu_req = 1'b0;
        else if (drop_m == 1) dma_req = 1'b0;
        tick();
        pl = (cpu_ready !== 1'b0) || (dma_ready !== 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b0; cpu_req = 1'b0; dma_req = 1'b0; cpu_we = 1'b0; dma_we = 1'b0;
        cpu_addr = 32'h0; dma_addr = 32'h0; cpu_wdata = 32'h0; dma_wdata = 32'h0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (3) tick();
        checks++;
        if ({cpu_ready, dma_ready, err, grant, mem_en, mem_we} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=000000", {cpu_ready, dma_ready, err, grant, mem_en, mem_we});
        end
        checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || cpu_rdata !== 32'h0 || dma_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_data got=%h/%h/%h/%h exp=0", mem_addr, mem_wdata, cpu_rdata, dma_rdata);
        end
        #3 rst = 1'b1;
        mdl_last = 1'b1;
        tick();
        checks++;
        if (mem_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle mem_en got=%b exp=0", mem_en);
        end
    endtask

    task automatic test_tie();
        int wn, lat; logic g, we, cr, dr, e, ew; logic [31:0] a, wd, crd, drd; bit un, pl;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0C00;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h0000_0D00;
        for (int k = 0; k < 3; k++) begin
            ew = exp_winner(1'b1, 1'b1, mdl_last);
            serve(0, 32'hA5A5_0000 + 32'(k), -1, wn, g, we, a, wd, lat, cr, dr, crd, drd, e, un, pl);
            checks++;
            if (g !== ew || a !== (ew ? 32'h0000_0D00 : 32'h0000_0C00) || wn != 1) begin
                failures++;
                $display("FAIL tie_grant[%0d] got grant=%b addr=%h wait=%0d exp grant=%b wait=1", k, g, a, wn, ew);
            end
            checks++;
            if (cr !== ~ew || dr !== ew || lat != 1) begin
                failures++;
                $display("FAIL tie_ready[%0d] got cpu=%b dma=%b lat=%0d exp cpu=%b dma=%b lat=1", k, cr, dr, lat, ~ew, ew);
            end
            mdl_last = ew;
        end
        cpu_req = 1'b0; dma_req = 1'b0;
    endtask

    task automatic test_cpu_read();
        int wn, lat; logic g, we, cr, dr, e; logic [31:0] a, wd, crd, drd; bit un, pl;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0100; cpu_wdata = $urandom;
        serve(0, 32'hDEAD_BEEF, 0, wn, g, we, a, wd, lat, cr, dr, crd, drd, e, un, pl);
        checks++;
        if (wn != 1 || a !== 32'h0000_0100 || we !== 1'b0 || g !== 1'b0) begin
            failures++;
            $display("FAIL cpu_read_issue got wait=%0d addr=%h we=%b grant=%b exp 1/100/0/0", wn, a, we, g);
        end
        checks++;
        if (lat != 1 || cr !== 1'b1 || dr !== 1'b0 || e !== 1'b0) begin
            failures++;
            $display("FAIL cpu_read_ready got lat=%0d cpu=%b dma=%b err=%b exp 1/1/0/0", lat, cr, dr, e);
        end
        checks++;
        if (crd !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL cpu_read_data got=%h exp=deadbeef", crd);
        end
        checks++;
        if (un || pl) begin
            failures++;
            $display("FAIL cpu_read_pulse got unstable=%b long_ready=%b exp 0/0", un, pl);
        end
        mdl_last = 1'b0;
    endtask

    task automatic test_dma_write();
        int wn, lat; logic g, we, cr, dr, e; logic [31:0] a, wd, crd, drd, ad; bit un, pl;
        ad = $urandom;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = ad; dma_wdata = 32'h1234_5678;
        serve(3, $urandom | 32'h1, 1, wn, g, we, a, wd, lat, cr, dr, crd, drd, e, un, pl);
        checks++;
        if (we !== 1'b1 || wd !== 32'h1234_5678 || a !== ad || g !== 1'b1) begin
            failures++;
            $display("FAIL dma_write_latch got we=%b wdata=%h addr=%h grant=%b exp 1/12345678/%h/1", we, wd, a, g, ad);
        end
        checks++;
        if (un) begin
            failures++;
            $display("FAIL dma_write_stable got unstable=1 exp 0");
        end
        checks++;
        if (lat != 4 || dr !== 1'b1 || cr !== 1'b0 || drd !== 32'h0 || e !== 1'b0) begin
            failures++;
            $display("FAIL dma_write_resp got lat=%0d dma=%b cpu=%b rdata=%h err=%b exp 4/1/0/0/0", lat, dr, cr, drd, e);
        end
        mdl_last = 1'b1;
    endtask

    task automatic test_timeout();
        int wn, lat; logic g, we, cr, dr, e; logic [31:0] a, wd, crd, drd, rd; bit un, pl, late;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0400;
        serve(-1, 32'h0, 0, wn, g, we, a, wd, lat, cr, dr, crd, drd, e, un, pl);
        checks++;
        if (lat != TIMEOUT + 1 || cr !== 1'b1 || e !== 1'b1 || crd !== 32'h0) begin
            failures++;
            $display("FAIL timeout_resp got lat=%0d ready=%b err=%b rdata=%h exp %0d/1/1/0", lat, cr, e, crd, TIMEOUT + 1);
        end
        mdl_last = 1'b0;
        late = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        repeat (3) begin
            tick();
            if (cpu_ready !== 1'b0 || dma_ready !== 1'b0 || mem_en !== 1'b0 || err !== 1'b0) late = 1'b1;
        end
        mem_ack = 1'b0;
        checks++;
        if (late) begin
            failures++;
            $display("FAIL timeout_late_ack got activity=1 exp 0");
        end
        rd = $urandom;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h0000_0500;
        serve(0, rd, 1, wn, g, we, a, wd, lat, cr, dr, crd, drd, e, un, pl);
        checks++;
        if (wn != 1 || lat != 1 || drd !== rd || e !== 1'b0) begin
            failures++;
            $display("FAIL timeout_recover got wait=%0d lat=%0d rdata=%h err=%b exp 1/1/%h/0", wn, lat, drd, e, rd);
        end
        mdl_last = 1'b1;
    endtask

    task automatic test_dma_stream();
        int wn, lat; logic g, we, cr, dr, e, ew; logic [31:0] a, wd, crd, drd; bit un, pl;
        dma_req = 1'b1; dma_we = 1'b0;
        for (int k = 0; k < 5; k++) begin
            dma_addr = 32'h0000_2000 + 32'(k * 4);
            if (k == 3) begin
                cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_3000;
            end
            ew = exp_winner(cpu_req, dma_req, mdl_last);
            serve(0, $urandom, (ew ? -1 : 0), wn, g, we, a, wd, lat, cr, dr, crd, drd, e, un, pl);
            checks++;
            if (g !== ew || wn != 1 || lat != 1) begin
                failures++;
                $display("FAIL stream_grant[%0d] got grant=%b wait=%0d lat=%0d exp grant=%b wait=1 lat=1", k, g, wn, lat, ew);
            end
            mdl_last = ew;
        end
        dma_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int n, wn, lat; logic g, we, cr, dr, e; logic [31:0] a, wd, crd, drd, rd; bit un, pl;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0A40;
        n = 0;
        do begin
            tick();
            n++;
        end while (mem_en !== 1'b1 && n < 10);
        checks++;
        if (mem_en !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_issue got mem_en=%b exp 1", mem_en);
        end
        tick();
        tick();
        #3 rst = 1'b0;
        #1;
        checks++;
        if ({cpu_ready, dma_ready, err, grant, mem_en, mem_we, mem_addr, mem_wdata, cpu_rdata, dma_rdata} !== '0) begin
            failures++;
            $display("FAIL rstmid_async got addr=%h en=%b rd=%h/%h exp all 0", mem_addr, mem_en, cpu_rdata, dma_rdata);
        end
        @(posedge clk);
        #3 rst = 1'b1;
        mdl_last = 1'b1;
        rd = $urandom;
        serve(1, rd, 0, wn, g, we, a, wd, lat, cr, dr, crd, drd, e, un, pl);
        checks++;
        if (wn != 1 || a !== 32'h0000_0A40 || lat != 2 || crd !== rd || cr !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_restart got wait=%0d addr=%h lat=%0d rdata=%h exp 1/a40/2/%h", wn, a, lat, crd, rd);
        end
        mdl_last = 1'b0;
    endtask

    task automatic test_random();
        int wn, lat, ack, elat; logic g, we, cr, dr, e, ew, ewe; logic [31:0] a, wd, crd, drd, rd, ea, ewd, erd;
        bit un, pl;
        logic [1:0] pend;
        pend = 2'b00;
        for (int it = 0; it < 40; it++) begin
            if (!pend[0] && $urandom_range(0, 1) == 1) pend[0] = 1'b1;
            if (!pend[1] && $urandom_range(0, 1) == 1) pend[1] = 1'b1;
            if (pend == 2'b00) pend[$urandom_range(0, 1)] = 1'b1;
            if (pend[0] && !cpu_req) begin
                cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1)); cpu_addr = $urandom; cpu_wdata = $urandom;
            end
            if (pend[1] && !dma_req) begin
                dma_req = 1'b1; dma_we = 1'($urandom_range(0, 1)); dma_addr = $urandom; dma_wdata = $urandom;
            end
            ew  = exp_winner(pend[0], pend[1], mdl_last);
            ewe = ew ? dma_we : cpu_we;
            ea  = ew ? dma_addr : cpu_addr;
            ewd = ew ? dma_wdata : cpu_wdata;
            ack = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 8));
            rd  = $urandom;
            elat = (ack < 0) ? TIMEOUT + 1 : ack + 1;
            erd  = (ewe || ack < 0) ? 32'h0 : rd;
            serve(ack, rd, int'(ew), wn, g, we, a, wd, lat, cr, dr, crd, drd, e, un, pl);
            checks++;
            if (wn != 1 || g !== ew || we !== ewe || a !== ea || wd !== ewd) begin
                failures++;
                $display("FAIL rand_latch[%0d] got wait=%0d grant=%b we=%b addr=%h wd=%h exp 1/%b/%b/%h/%h", it, wn, g, we, a, wd, ew, ewe, ea, ewd);
            end
            checks++;
            if (lat != elat || cr !== ~ew || dr !== ew || e !== (ack < 0)) begin
                failures++;
                $display("FAIL rand_resp[%0d] got lat=%0d cpu=%b dma=%b err=%b exp %0d/%b/%b/%b", it, lat, cr, dr, e, elat, ~ew, ew, (ack < 0));
            end
            checks++;
            if ((ew ? drd : crd) !== erd || un || pl) begin
                failures++;
                $display("FAIL rand_data[%0d] got rdata=%h unstable=%b long=%b exp %h/0/0", it, (ew ? drd : crd), un, pl, erd);
            end
            pend[ew] = 1'b0;
            mdl_last = ew;
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_tie();
        test_cpu_read();
        test_dma_write();
        test_timeout();
        test_dma_stream();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
